// File: rtl/io_port_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_unit_if
//  Description : External stream bundle for io_port_unit. It carries the
//                outgoing word stream toward a sink and the incoming word
//                stream from a source, each with a valid/ready handshake.
//                master = the I/O unit side, slave = the external peer.
//  Revision    : 1.0  initial release
// ============================================================================
interface io_port_unit_if #(
    parameter int DATA_W = 16
);
    // Outgoing stream (I/O unit -> sink)
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Incoming stream (source -> I/O unit)
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        input  in_valid,
        output in_ready,
        input  in_data
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        output in_valid,
        input  in_ready,
        output in_data
    );
endinterface
`default_nettype wire

// File: rtl/io_port_unit.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_unit
//  Description : Memory-less I/O responder for the CPU `in` / `out` states.
//                Outgoing words pushed by OutputWrite are queued in a small
//                FIFO and offered to an external sink. One incoming word from
//                an external source is held for the CPU until InputRead
//                consumes it.
//                Optional macro IO_ERR_FLAGS_EN adds sticky Overflow /
//                Underflow flags and an ErrClear input.
//  Revision    : 1.0  initial release
// ============================================================================
module io_port_unit #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4
) (
    input  wire logic              CLK,
    input  wire logic              Reset_n,

    // Control-unit side
    input  wire logic              OutputWrite,
    input  wire logic [DATA_W-1:0] OutData,
    input  wire logic              InputRead,
    output      logic [DATA_W-1:0] InData,
    output      logic              OutFull,
    output      logic              InAvail,
`ifdef IO_ERR_FLAGS_EN
    output      logic              Overflow,
    output      logic              Underflow,
    input  wire logic              ErrClear,
`endif

    // External sink / source streams
    io_port_unit_if.master         bus
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PONE  = PTR_W'(1);

    // ------------------------------------------------------------------------
    // Output FIFO state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    logic w_outValid;
    logic w_full;
    logic w_pop;
    logic w_push;

    // ------------------------------------------------------------------------
    // Input holding register state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_inBuf;
    logic              r_inAvail;
    logic              w_inReady;
    logic              w_accept;

    // A pop frees a slot in the same cycle, so a push is allowed into a full
    // FIFO only when the sink is taking the head word at that edge.
    always_comb begin
        w_outValid = (r_count != '0);
        w_full     = (r_count == c_DEPTH);
        w_pop      = w_outValid & bus.out_ready;
        w_push     = OutputWrite & (~w_full | w_pop);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array is not reset: a slot is only ever read after it was written.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= OutData;
        end
    end

    // Sink-facing outputs come straight from registered state.
    always_comb begin
        bus.out_valid = w_outValid;
        bus.out_data  = r_mem[r_rdPtr];
        OutFull       = w_full;
    end

    // The holding register can take a new word whenever it is empty or the
    // CPU is draining it in this very cycle.
    always_comb begin
        w_inReady    = ~r_inAvail | InputRead;
        w_accept     = bus.in_valid & w_inReady;
        bus.in_ready = w_inReady;
        InData       = r_inBuf;
        InAvail      = r_inAvail;
    end

    // Capture wins over consume: a same-cycle read hands the CPU the old word
    // while the new one lands and keeps the register valid.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_inBuf   <= '0;
            r_inAvail <= 1'b0;
        end else if (w_accept) begin
            r_inBuf   <= bus.in_data;
            r_inAvail <= 1'b1;
        end else if (InputRead) begin
            r_inAvail <= 1'b0;
        end
    end

`ifdef IO_ERR_FLAGS_EN
    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    logic r_overflow;
    logic r_underflow;
    logic w_drop;
    logic w_underRead;

    // A dropped push is a strobe that the FIFO could not absorb; an underflow
    // is a consume strobe with nothing held.
    always_comb begin
        w_drop      = OutputWrite & ~w_push;
        w_underRead = InputRead & ~r_inAvail;
        Overflow    = r_overflow;
        Underflow   = r_underflow;
    end

    // Each flag sets on its event and clears on ErrClear; a set event in the
    // same cycle takes priority so no error is lost.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ErrClear) begin
                r_overflow <= 1'b0;
            end
            if (w_underRead) begin
                r_underflow <= 1'b1;
            end else if (ErrClear) begin
                r_underflow <= 1'b0;
            end
        end
    end
`else
    // Without error flags, dropped pushes and empty reads are silent.
`endif

endmodule
`default_nettype wire
